uart_command_parser: RTL

Upstream stage of wishbone_master. Converts a stream of received UART bytes into one 32-bit command word, one 32-bit address word and one 32-bit data word. Frames are ASCII: a start character followed by exactly 24 hex digits (8 command, 8 address, 8 data, MSB nibble first). A completed frame is dispatched to the master with a one-cycle ready pulse, gated by master_ready.

---
 rtl/uart_command_parser_if.sv | 20 ++
 rtl/uart_command_parser.sv | 110 +++++++++++
 2 files changed

// File: rtl/uart_command_parser_if.sv
// uart_command_parser_if: byte stream in, parsed command/address/data and status pulses out.
interface uart_command_parser_if;
    logic        byte_available;
    logic [7:0]  rx_byte;
    logic        master_ready;
    logic [31:0] command;
    logic [31:0] address;
    logic [31:0] data;
    logic        ready;
    logic        error;
    logic        overrun;
    modport slave (
        input  byte_available, rx_byte, master_ready,
        output command, address, data, ready, error, overrun
    );
    modport master (
        output byte_available, rx_byte, master_ready,
        input  command, address, data, ready, error, overrun
    );
endinterface

// File: rtl/uart_command_parser.sv
// uart_command_parser: assembles 'L' + 24 hex digits into command/address/data words.
module uart_command_parser #(
    parameter logic [7:0] START_CHAR     = 8'h4C,
    parameter int         TIMEOUT_CYCLES = 1000,
    parameter int         TIMEOUT_WIDTH  = 16
) (
    input logic clk,
    input logic rst,
    uart_command_parser_if.slave bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] DISPATCH = 2'd2;
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LIMIT = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
    logic [1:0]               state_q, state_d;
    logic [4:0]               cnt_q, cnt_d;
    logic [TIMEOUT_WIDTH-1:0] to_q, to_d;
    logic [31:0]              cmd_q, cmd_d, addr_q, addr_d, data_q, data_d;
    logic                     ready_q, ready_d, error_q, error_d, overrun_q, overrun_d;
    logic [7:0]               b;
    logic                     is_hex, is_start;
    logic [3:0]               nib;
    assign b        = bus.rx_byte;
    assign is_start = bus.byte_available && b == START_CHAR;
    assign is_hex   = (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
    // letters of either case share the low nibble offset: 'A'/'a' low nibble 1 -> 10
    assign nib      = (b <= 8'h39) ? b[3:0] : b[3:0] + 4'd9;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_start) begin
                    state_d = COLLECT;
                    {cmd_d, addr_d, data_d} = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                end
            end
            COLLECT: begin
                if (!bus.byte_available) begin
                    to_d = to_q + 1'b1;
                    if (to_d == TO_LIMIT) begin
                        error_d = 1'b1;
                        state_d = IDLE;
                    end
                end else if (is_hex) begin
                    cnt_d   = cnt_q + 5'd1;
                    to_d    = '0;
                    cmd_d   = (cnt_q < 5'd8) ? {cmd_q[27:0], nib} : cmd_q;
                    addr_d  = (cnt_q >= 5'd8 && cnt_q < 5'd16) ? {addr_q[27:0], nib} : addr_q;
                    data_d  = (cnt_q >= 5'd16) ? {data_q[27:0], nib} : data_q;
                    state_d = (cnt_q == 5'd23) ? DISPATCH : COLLECT;
                end else if (is_start) begin
                    error_d = 1'b1;
                    {cmd_d, addr_d, data_d} = '0;
                    cnt_d   = '0;
                    to_d    = '0;
                end else begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end
            end
            DISPATCH: begin
                overrun_d = bus.byte_available;
                if (bus.master_ready) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            to_q      <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            overrun_q <= overrun_d;
        end
    end
    assign bus.command = cmd_q;
    assign bus.address = addr_q;
    assign bus.data    = data_q;
    assign bus.ready   = ready_q;
    assign bus.error   = error_q;
    assign bus.overrun = overrun_q;
endmodule
